// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit asynchronous SRAM between the instruction-fetch and data ports.
// Each 32-bit word is moved as two halfword cycles, low half first.
module sram_port_arbiter #(
   parameter bit MEM_FIRST = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_mc_en,
   input  logic [17:0] if_mc_addr,
   output logic [31:0] mc_if_data,
   output logic        mc_if_ack,
   input  logic        mem_mc_en,
   input  logic        mem_mc_rw,
   input  logic [17:0] mem_mc_addr,
   input  logic [31:0] mem_mc_wdata,
   output logic [31:0] mc_mem_rdata,
   output logic        mc_mem_ack,
   output logic [17:0] mc_ram_addr,
   output logic        mc_ram_we_n,
   output logic        mc_ram_oe_n,
   output logic [15:0] mc_ram_dq_out,
   output logic        mc_ram_dq_oe,
   input  logic [15:0] ram_mc_dq_in
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LO   = 3'd1,
      RD_HI   = 3'd2,
      WR_LO_S = 3'd3,
      WR_LO_P = 3'd4,
      WR_HI_S = 3'd5,
      WR_HI_P = 3'd6,
      ACK     = 3'd7
   } state_t;

   state_t      state_r, state_nx_s;
   logic        gnt_mem_r, gnt_mem_nx_s;
   logic [15:0] word_r, word_nx_s;
   logic [31:0] wdata_r, wdata_nx_s;
   logic [15:0] lo_r;
   logic        last_mem_r;
   logic        granted_r;
   logic        grant_s;
   logic        pick_mem_s;

   logic [17:0] ram_addr_nx_s;
   logic        we_n_nx_s;
   logic        oe_n_nx_s;
   logic        dq_oe_nx_s;
   logic [15:0] dq_out_nx_s;

   // Byte-lane bits of the request addresses have no meaning on a word bus.
   logic [3:0]  unused_addr_bits_s;
   assign unused_addr_bits_s = {if_mc_addr[1:0], mem_mc_addr[1:0]};

   function automatic logic [17:0] half_addr(input logic [15:0] word, input logic hi);
      return {1'b0, word, hi};
   endfunction

   // Arbitration, request latching and state sequencing.
   always_comb begin
      state_nx_s   = state_r;
      gnt_mem_nx_s = gnt_mem_r;
      word_nx_s    = word_r;
      wdata_nx_s   = wdata_r;
      grant_s      = 1'b0;
      if (if_mc_en && mem_mc_en) begin
         pick_mem_s = granted_r ? !last_mem_r : MEM_FIRST;
      end else begin
         pick_mem_s = mem_mc_en;
      end
      case (state_r)
         IDLE: begin
            if (if_mc_en || mem_mc_en) begin
               grant_s      = 1'b1;
               gnt_mem_nx_s = pick_mem_s;
               word_nx_s    = pick_mem_s ? mem_mc_addr[17:2] : if_mc_addr[17:2];
               wdata_nx_s   = mem_mc_wdata;
               state_nx_s   = (pick_mem_s && mem_mc_rw) ? WR_LO_S : RD_LO;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RD_LO:   state_nx_s = RD_HI;
         RD_HI:   state_nx_s = ACK;
         WR_LO_S: state_nx_s = WR_LO_P;
         WR_LO_P: state_nx_s = WR_HI_S;
         WR_HI_S: state_nx_s = WR_HI_P;
         WR_HI_P: state_nx_s = ACK;
         ACK:     state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // SRAM pin values for the upcoming cycle, decoded from the next state so the pins are registered.
   always_comb begin
      ram_addr_nx_s = mc_ram_addr;
      we_n_nx_s     = 1'b1;
      oe_n_nx_s     = 1'b1;
      dq_oe_nx_s    = 1'b0;
      dq_out_nx_s   = mc_ram_dq_out;
      case (state_nx_s)
         RD_LO: begin
            ram_addr_nx_s = half_addr(word_nx_s, 1'b0);
            oe_n_nx_s     = 1'b0;
         end
         RD_HI: begin
            ram_addr_nx_s = half_addr(word_nx_s, 1'b1);
            oe_n_nx_s     = 1'b0;
         end
         WR_LO_S, WR_LO_P: begin
            ram_addr_nx_s = half_addr(word_nx_s, 1'b0);
            dq_out_nx_s   = wdata_nx_s[15:0];
            dq_oe_nx_s    = 1'b1;
            we_n_nx_s     = (state_nx_s == WR_LO_P) ? 1'b0 : 1'b1;
         end
         WR_HI_S, WR_HI_P: begin
            ram_addr_nx_s = half_addr(word_nx_s, 1'b1);
            dq_out_nx_s   = wdata_nx_s[31:16];
            dq_oe_nx_s    = 1'b1;
            we_n_nx_s     = (state_nx_s == WR_HI_P) ? 1'b0 : 1'b1;
         end
         default: begin
            ram_addr_nx_s = mc_ram_addr;
            dq_out_nx_s   = mc_ram_dq_out;
         end
      endcase
   end

   // State, latched transaction and arbitration history.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         gnt_mem_r  <= 1'b0;
         word_r     <= 16'h0000;
         wdata_r    <= 32'h0000_0000;
         last_mem_r <= 1'b0;
         granted_r  <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         gnt_mem_r <= gnt_mem_nx_s;
         word_r    <= word_nx_s;
         wdata_r   <= wdata_nx_s;
         if (grant_s) begin
            last_mem_r <= pick_mem_s;
            granted_r  <= 1'b1;
         end
      end
   end

   // Registered SRAM pins; reset pulls the write strobe high without waiting for a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mc_ram_addr   <= 18'h00000;
         mc_ram_we_n   <= 1'b1;
         mc_ram_oe_n   <= 1'b1;
         mc_ram_dq_oe  <= 1'b0;
         mc_ram_dq_out <= 16'h0000;
      end else begin
         mc_ram_addr   <= ram_addr_nx_s;
         mc_ram_we_n   <= we_n_nx_s;
         mc_ram_oe_n   <= oe_n_nx_s;
         mc_ram_dq_oe  <= dq_oe_nx_s;
         mc_ram_dq_out <= dq_out_nx_s;
      end
   end

   // Read-data assembly and completion pulses for the granted port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lo_r         <= 16'h0000;
         mc_if_data   <= 32'h0000_0000;
         mc_mem_rdata <= 32'h0000_0000;
         mc_if_ack    <= 1'b0;
         mc_mem_ack   <= 1'b0;
      end else begin
         mc_if_ack  <= (state_nx_s == ACK) && !gnt_mem_r;
         mc_mem_ack <= (state_nx_s == ACK) && gnt_mem_r;
         if (state_r == RD_LO) begin
            lo_r <= ram_mc_dq_in;
         end
         if (state_r == RD_HI) begin
            if (gnt_mem_r) begin
               mc_mem_rdata <= {ram_mc_dq_in, lo_r};
            end else begin
               mc_if_data <= {ram_mc_dq_in, lo_r};
            end
         end
      end
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Sequencer/arbiter that shares the single 16-bit asynchronous SRAM between the instruction-fetch port and the data-memory port of the processor.
- Each 32-bit word access is split into two 16-bit SRAM cycles: low half first, high half second.
- The block generates SRAM address, write strobe, output enable and data-bus drive.
- It sits between the pipeline's IF/MEM stages and the board-level SRAM pins; the top level builds the tristate from `mc_ram_dq_out`/`mc_ram_dq_oe`.

## Interface
Parameters:
- `MEM_FIRST`, default 1. Arbitration winner when both ports request and no grant has yet been issued since reset (1 = MEM, 0 = IF).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_mc_en`  in  1  fetch request, held until `mc_if_ack`.
- `if_mc_addr`  in  18  fetch byte address; bits [1:0] ignored.
- `mc_if_data`  out  32  fetched word, valid in the `mc_if_ack` cycle, held until the next IF ack.
- `mc_if_ack`  out  1  one-cycle completion pulse for IF.
- `mem_mc_en`  in  1  data request, held until `mc_mem_ack`.
- `mem_mc_rw`  in  1  1 = write, 0 = read.
- `mem_mc_addr`  in  18  data byte address; bits [1:0] ignored.
- `mem_mc_wdata`  in  32  write data.
- `mc_mem_rdata`  out  32  read word, valid in the `mc_mem_ack` cycle, held until the next MEM read ack.
- `mc_mem_ack`  out  1  one-cycle completion pulse for MEM.
- `mc_ram_addr`  out  18  SRAM halfword address.
- `mc_ram_we_n`  out  1  SRAM write strobe, active low.
- `mc_ram_oe_n`  out  1  SRAM output enable, active low.
- `mc_ram_dq_out`  out  16  data driven to SRAM.
- `mc_ram_dq_oe`  out  1  1 = drive `mc_ram_dq_out` onto the bus.
- `ram_mc_dq_in`  in  16  data read from SRAM.

## Operation
- **Address mapping:** halfword address = {1'b0, addr[17:2], h}, where h = 0 for the low half (word bits [15:0]) and h = 1 for the high half (bits [31:16]). Little-endian.
- **States:** IDLE, RD_LO, RD_HI, WR_LO_S, WR_LO_P, WR_HI_S, WR_HI_P, ACK.
- **IDLE:** samples `if_mc_en` and `mem_mc_en`.
  - Winner goes to RD_LO (IF, or MEM with rw = 0) or WR_LO_S (MEM with rw = 1).
  - Granted port, address, rw and wdata are latched at the grant edge; later changes on the inputs do not affect the transaction in flight.
- **Arbitration:**
  - A single requester wins.
  - If both request, the port not granted last wins (alternating).
  - Before the first grant after reset, the tie goes to `MEM_FIRST`.
- **Read path:**
  - RD_LO: `mc_ram_addr` = low, `mc_ram_oe_n` = 0; the low half is captured at the exit edge.
  - RD_HI: `mc_ram_addr` = high, `mc_ram_oe_n` = 0; the high half is captured at the exit edge into the granted port's data register.
- **Write path:**
  - *_S (setup) states: addr and dq are driven, `mc_ram_dq_oe` = 1, `mc_ram_we_n` = 1.
  - *_P (pulse) states: same addr and dq, `mc_ram_we_n` = 0.
  - addr and data are stable one full cycle before and throughout the strobe.
- **ACK:** asserts the granted port's ack for exactly one cycle, then goes to IDLE unconditionally. A requester still holding en in the cycle after its ack is treated as a new request.
- **Idle outputs:** outside active states, `mc_ram_we_n` = 1, `mc_ram_oe_n` = 1, `mc_ram_dq_oe` = 0, and `mc_ram_addr` holds its last value.
- **Reset values:**
  - state IDLE; `mc_ram_addr` = 0; `mc_ram_we_n` = 1; `mc_ram_oe_n` = 1; `mc_ram_dq_oe` = 0; `mc_ram_dq_out` = 0.
  - both acks 0; `mc_if_data` = 0; `mc_mem_rdata` = 0; arbitration history cleared.
- **Reset mid-transaction:** immediate return to IDLE, `mc_ram_we_n` forced high asynchronously, no ack issued, partial read data discarded (output registers cleared).
- All SRAM-side outputs are registered; there are no combinational paths from request inputs to SRAM pins.

## Timing
- Edge E0 samples the request. The first access state occupies the cycle after E0.
- **Read:** RD_LO in cycle 1, RD_HI in cycle 2, ACK in cycle 3. Ack and data are valid 3 cycles after E0.
- **Write:** WR_LO_S, WR_LO_P, WR_HI_S, WR_HI_P in cycles 1–4, ACK in cycle 5.
- Minimum spacing between grants: one IDLE cycle after ACK. Back-to-back reads give one word per 4 cycles; back-to-back writes give one word per 6 cycles.
- **Simultaneous requests:** the loser waits. Under continuous contention it is guaranteed the next grant, so worst-case wait is one full transaction of the other port plus one IDLE cycle.
- `mem_mc_rw` and addresses are sampled only at the grant edge.

## Test plan
- Reset, then MEM write 0xDEADBEEF to byte address 0x00010 → SRAM sees addr 0x00008 with data 0xBEEF and one low-strobe cycle, then addr 0x00009 with data 0xDEAD; `mc_mem_ack` pulses in cycle 5.
- IF read of address 0x00010 with SRAM model holding the values above → `mc_if_data` = 0xDEADBEEF, `mc_if_ack` in cycle 3, `mc_ram_oe_n` low only in cycles 1–2.
- Both en raised in the same cycle after reset (`MEM_FIRST` = 1), both held continuously → grants alternate MEM, IF, MEM, …; each ack pulses exactly one cycle.
- Address 0x00013 (misaligned) → accesses halfwords 0x00008 and 0x00009, identical to 0x00010.
- Assert `reset` during WR_LO_P → `mc_ram_we_n` rises immediately, no ack, block returns to IDLE; a following read returns the data that was stored before.
- Change `mem_mc_addr`/`mem_mc_wdata` during an in-flight write → SRAM still receives the values latched at grant.
